// File: rtl/i2c_target_block_pkg.sv
// Shared types and constants for the I2C target block.
// FSM encodings and bus-level bit meanings.
package i2c_target_block_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_target_block_if.sv
// I2C pins plus register-file port of the target block.
// slave = target side, master = environment side.
interface i2c_target_block_if #(
    parameter int DATA_BYTES = 2
);
    logic                    scl_in;
    logic                    sda_in;
    logic                    sda_out;
    logic                    sda_oen;
    logic [7:0]              reg_addr;
    logic [8*DATA_BYTES-1:0] reg_rdata;
    logic [8*DATA_BYTES-1:0] reg_wdata;
    logic                    reg_wr_en;
    logic                    busy;
    logic                    done;

    modport slave (
        input  scl_in, sda_in, reg_rdata,
        output sda_out, sda_oen, reg_addr,
        output reg_wdata, reg_wr_en, busy, done
    );

    modport master (
        output scl_in, sda_in, reg_rdata,
        input  sda_out, sda_oen, reg_addr,
        input  reg_wdata, reg_wr_en, busy, done
    );
endinterface

// File: rtl/i2c_bus_cond.sv
// I2C input conditioning: synchronizers, SCL edge strobes,
// START/STOP strobes. Bus idles high, so flops reset to 1.
module i2c_bus_cond #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_d;
    logic                   sda_d;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda   = sda_sync[SYNC_STAGES-1];

    // Synchronize both lines and keep one delayed copy for edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda;
        end
    end

    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & sda_d & ~sda;
    assign stop     = scl_s & scl_d & ~sda_d & sda;
endmodule

// File: rtl/i2c_target_block.sv
// I2C target with auto-incrementing register pointer.
// Block writes and pointer-then-repeated-START block reads.
module i2c_target_block
    import i2c_target_block_pkg::*;
#(
    parameter int DATA_BYTES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        chip_addr,
    i2c_target_block_if.slave bus
);
    localparam int         WW        = 8 * DATA_BYTES;
    localparam logic [1:0] LAST_BYTE = 2'(DATA_BYTES - 1);

    logic          sda_s;
    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;

    state_t        state;
    logic [3:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [7:0]    shift;
    logic          rw;
    logic          sda_oen_q;
    logic          busy_q;
    logic          done_q;
    logic          wr_en_q;
    logic [7:0]    addr_q;
    logic [WW-1:0] wdata_q;

    logic [7:0]    rx_byte;
    logic          addr_hit;
    logic [WW-1:0] rd_word;
    logic [7:0]    rd_byte;

    i2c_bus_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_cond (
        .clk     (clk),
        .reset   (reset),
        .scl_in  (bus.scl_in),
        .sda_in  (bus.sda_in),
        .sda     (sda_s),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start_det),
        .stop    (stop_det)
    );

    assign rx_byte  = {shift[6:0], sda_s};
    assign addr_hit = (rx_byte[7:1] == chip_addr)
                   && (rx_byte[7:1] != 7'd0);
    assign rd_word  = bus.reg_rdata << {byte_cnt, 3'b000};
    assign rd_byte  = rd_word[WW-1 -: 8];

    // Protocol FSM; all bus and register outputs are registered here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            byte_cnt  <= 2'd0;
            shift     <= 8'd0;
            rw        <= 1'b0;
            sda_oen_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= 8'd0;
            wdata_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            if (wr_en_q)
                addr_q <= addr_q + 8'd1;
            if (start_det) begin
                state     <= ST_ADDR;
                bit_cnt   <= 4'd0;
                byte_cnt  <= 2'd0;
                sda_oen_q <= 1'b1;
            end else if (stop_det) begin
                state     <= ST_IDLE;
                bit_cnt   <= 4'd0;
                byte_cnt  <= 2'd0;
                sda_oen_q <= 1'b1;
                done_q    <= busy_q;
                busy_q    <= 1'b0;
            end else begin
                unique case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if (addr_hit) begin
                                    busy_q <= 1'b1;
                                    rw     <= rx_byte[0];
                                end else begin
                                    busy_q <= 1'b0;
                                    state  <= ST_IGNORE;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oen_q <= I2C_ACK;
                            bit_cnt   <= 4'd0;
                            state     <= ST_ADDR_ACK;
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw == RW_READ) begin
                                shift     <= {rd_byte[6:0], 1'b1};
                                sda_oen_q <= rd_byte[7];
                                state     <= ST_RDATA;
                            end else begin
                                sda_oen_q <= 1'b1;
                                state     <= ST_PTR;
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7)
                                addr_q <= rx_byte;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oen_q <= I2C_ACK;
                            bit_cnt   <= 4'd0;
                            state     <= ST_PTR_ACK;
                        end
                    end
                    ST_PTR_ACK: begin
                        if (scl_fall) begin
                            sda_oen_q <= 1'b1;
                            bit_cnt   <= 4'd0;
                            state     <= ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        if (scl_rise) begin
                            shift   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                wdata_q <= (wdata_q << 8) | WW'(rx_byte);
                                if (byte_cnt == LAST_BYTE) begin
                                    wr_en_q  <= 1'b1;
                                    byte_cnt <= 2'd0;
                                end else begin
                                    byte_cnt <= byte_cnt + 2'd1;
                                end
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oen_q <= I2C_ACK;
                            bit_cnt   <= 4'd0;
                            state     <= ST_WDATA_ACK;
                        end
                    end
                    ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oen_q <= 1'b1;
                            bit_cnt   <= 4'd0;
                            state     <= ST_WDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oen_q <= 1'b1;
                                bit_cnt   <= 4'd0;
                                state     <= ST_RDATA_ACK;
                            end else begin
                                sda_oen_q <= shift[7];
                                shift     <= {shift[6:0], 1'b1};
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_s == I2C_NACK) begin
                                sda_oen_q <= 1'b1;
                                state     <= ST_IGNORE;
                            end else if (byte_cnt == LAST_BYTE) begin
                                addr_q   <= addr_q + 8'd1;
                                byte_cnt <= 2'd0;
                            end else begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                        end else if (scl_fall) begin
                            shift     <= {rd_byte[6:0], 1'b1};
                            sda_oen_q <= rd_byte[7];
                            bit_cnt   <= 4'd0;
                            state     <= ST_RDATA;
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                        sda_oen_q <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sda_out   = 1'b0;
    assign bus.sda_oen   = sda_oen_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr_en = wr_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_i2c_target_block.sv
// Bench for i2c_target_block: bit-banged I2C master,
// register-file model and write/read scoreboards.
module tb_i2c_target_block;
    import i2c_target_block_pkg::*;

    localparam int Q = 250;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] chip_addr = 7'h0F;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [15:0] regfile [256];
    logic [15:0] rd_d1;
    logic [7:0]  exp_wa_q[$];
    logic [15:0] exp_wd_q[$];
    logic [7:0]  obs_wa_q[$];
    logic [15:0] obs_wd_q[$];
    logic [7:0]  exp_rd_q[$];
    int          done_cnt = 0;
    logic        busy_seen = 1'b0;

    i2c_target_block_if #(.DATA_BYTES(2)) bif();

    i2c_target_block #(
        .DATA_BYTES (2),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .chip_addr(chip_addr),
        .bus      (bif)
    );

    always #22 clk = ~clk;

    assign bif.scl_in = scl_m;
    assign bif.sda_in = sda_m & (bif.sda_oen | bif.sda_out);

    // Register file read port with two-clock latency
    always @(posedge clk) begin
        rd_d1         <= regfile[bif.reg_addr];
        bif.reg_rdata <= rd_d1;
    end

    // Monitor: record writes, done pulses and busy
    always @(negedge clk) begin
        if (bif.reg_wr_en) begin
            obs_wa_q.push_back(bif.reg_addr);
            obs_wd_q.push_back(bif.reg_wdata);
        end
        if (bif.done)
            done_cnt = done_cnt + 1;
        if (bif.busy)
            busy_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #(2*Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = bif.sda_in; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--)
            put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--)
            get_bit(d[i]);
        put_bit(ack);
    endtask

    task automatic wr_txn(input logic [7:0] ptr,
                          input logic [7:0] data[$],
                          output int nacks);
        logic a;
        nacks = 0;
        bus_start();
        write_byte({chip_addr, 1'b0}, a);
        nacks += int'(a);
        write_byte(ptr, a);
        nacks += int'(a);
        foreach (data[i]) begin
            write_byte(data[i], a);
            nacks += int'(a);
        end
        bus_stop();
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_wa_q.delete();
        obs_wd_q.delete();
        done_cnt  = 0;
        busy_seen = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bif.sda_oen !== 1'b1) begin
            errors++;
            $display("FAIL rst_sda_oen: got %b want 1", bif.sda_oen);
        end
        checks++;
        if (bif.sda_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_sda_out: got %b want 0", bif.sda_out);
        end
        checks++;
        if (bif.reg_addr !== 8'h00) begin
            errors++;
            $display("FAIL rst_reg_addr: got %h want 00", bif.reg_addr);
        end
        checks++;
        if (bif.reg_wdata !== 16'h0000) begin
            errors++;
            $display("FAIL rst_reg_wdata: got %h want 0000", bif.reg_wdata);
        end
        checks++;
        if ({bif.reg_wr_en, bif.busy, bif.done} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags: got %b want 000",
                     {bif.reg_wr_en, bif.busy, bif.done});
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write();
        int nacks;
        logic [7:0] ea, oa;
        logic [15:0] ed, od;
        clear_obs();
        exp_wa_q.push_back(8'h0A);
        exp_wd_q.push_back(16'hB2B2);
        wr_txn(8'h0A, '{8'hB2, 8'hB2}, nacks);
        checks++;
        if (nacks !== 0) begin
            errors++;
            $display("FAIL wr_acks: got %0d nacks want 0", nacks);
        end
        while (exp_wa_q.size() > 0) begin
            ea = exp_wa_q.pop_front();
            ed = exp_wd_q.pop_front();
            checks++;
            if (obs_wa_q.size() == 0) begin
                errors++;
                $display("FAIL wr_missing: got none want %h@%h", ed, ea);
            end else begin
                oa = obs_wa_q.pop_front();
                od = obs_wd_q.pop_front();
                if ({oa, od} !== {ea, ed}) begin
                    errors++;
                    $display("FAIL wr_word: got %h@%h want %h@%h",
                             od, oa, ed, ea);
                end
            end
        end
        checks++;
        if (obs_wa_q.size() != 0) begin
            errors++;
            $display("FAIL wr_extra: got %0d extra want 0", obs_wa_q.size());
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL wr_done: got %0d pulses want 1", done_cnt);
        end
        checks++;
        if (busy_seen !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy: got %b want 1", busy_seen);
        end
        checks++;
        if (bif.reg_addr !== 8'h0B) begin
            errors++;
            $display("FAIL wr_ptr_after: got %h want 0B", bif.reg_addr);
        end
    endtask

    task automatic test_read();
        logic a;
        logic [7:0] got, exp;
        int nacks = 0;
        clear_obs();
        regfile[8'h10] = 16'hC3C3;
        regfile[8'h11] = 16'hD4D4;
        exp_rd_q.push_back(8'hC3);
        exp_rd_q.push_back(8'hC3);
        exp_rd_q.push_back(8'hD4);
        exp_rd_q.push_back(8'hD4);
        bus_start();
        write_byte({chip_addr, 1'b0}, a);
        nacks += int'(a);
        write_byte(8'h10, a);
        nacks += int'(a);
        bus_start();
        write_byte({chip_addr, RW_READ}, a);
        nacks += int'(a);
        checks++;
        if (nacks !== 0) begin
            errors++;
            $display("FAIL rd_acks: got %0d nacks want 0", nacks);
        end
        for (int i = 0; i < 4; i++) begin
            read_byte((i == 3) ? I2C_NACK : I2C_ACK, got);
            exp = exp_rd_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rd_byte%0d: got %h want %h", i, got, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (bif.sda_oen !== 1'b1) begin
            errors++;
            $display("FAIL rd_release: got %b want 1", bif.sda_oen);
        end
        checks++;
        if (bif.reg_addr !== 8'h11) begin
            errors++;
            $display("FAIL rd_ptr: got %h want 11", bif.reg_addr);
        end
        bus_stop();
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt != 1 || obs_wa_q.size() != 0) begin
            errors++;
            $display("FAIL rd_done_nowr: got done=%0d wr=%0d want 1 0",
                     done_cnt, obs_wa_q.size());
        end
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1;
        clear_obs();
        bus_start();
        write_byte({7'h0E, 1'b0}, a0);
        write_byte(8'h55, a1);
        bus_stop();
        repeat (4) @(negedge clk);
        checks++;
        if ({a0, a1} !== 2'b11) begin
            errors++;
            $display("FAIL mis_nack: got %b want 11", {a0, a1});
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++;
            $display("FAIL mis_busy: got %b want 0", busy_seen);
        end
        checks++;
        if (obs_wa_q.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL mis_quiet: got wr=%0d done=%0d want 0 0",
                     obs_wa_q.size(), done_cnt);
        end
    endtask

    task automatic test_wrap();
        int nacks;
        logic [7:0] ea, oa;
        logic [15:0] ed, od;
        clear_obs();
        exp_wa_q.push_back(8'hFF);
        exp_wd_q.push_back(16'h1111);
        exp_wa_q.push_back(8'h00);
        exp_wd_q.push_back(16'h2222);
        wr_txn(8'hFF, '{8'h11, 8'h11, 8'h22, 8'h22}, nacks);
        checks++;
        if (nacks !== 0) begin
            errors++;
            $display("FAIL wrap_acks: got %0d nacks want 0", nacks);
        end
        while (exp_wa_q.size() > 0) begin
            ea = exp_wa_q.pop_front();
            ed = exp_wd_q.pop_front();
            checks++;
            if (obs_wa_q.size() == 0) begin
                errors++;
                $display("FAIL wrap_missing: got none want %h@%h", ed, ea);
            end else begin
                oa = obs_wa_q.pop_front();
                od = obs_wd_q.pop_front();
                if ({oa, od} !== {ea, ed}) begin
                    errors++;
                    $display("FAIL wrap_word: got %h@%h want %h@%h",
                             od, oa, ed, ea);
                end
            end
        end
        checks++;
        if (obs_wa_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_extra: got %0d want 0", obs_wa_q.size());
        end
        checks++;
        if (bif.reg_addr !== 8'h01) begin
            errors++;
            $display("FAIL wrap_ptr: got %h want 01", bif.reg_addr);
        end
    endtask

    task automatic test_partial();
        int nacks;
        clear_obs();
        wr_txn(8'h20, '{8'hAB}, nacks);
        checks++;
        if (obs_wa_q.size() != 0) begin
            errors++;
            $display("FAIL part_wr: got %0d writes want 0", obs_wa_q.size());
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL part_done: got %0d want 1", done_cnt);
        end
        checks++;
        if (bif.reg_addr !== 8'h20) begin
            errors++;
            $display("FAIL part_ptr: got %h want 20", bif.reg_addr);
        end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        clear_obs();
        regfile[8'h30] = 16'h0000;
        bus_start();
        write_byte({chip_addr, 1'b0}, a);
        write_byte(8'h30, a);
        bus_start();
        write_byte({chip_addr, RW_READ}, a);
        @(negedge clk);
        checks++;
        if (bif.sda_oen !== 1'b0 || dut.state !== ST_RDATA) begin
            errors++;
            $display("FAIL mid_drive: got oen=%b st=%0d want 0 %0d",
                     bif.sda_oen, dut.state, ST_RDATA);
        end
        #5;
        reset = 1'b0;
        #1;
        checks++;
        if (bif.sda_oen !== 1'b1 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got oen=%b busy=%b want 1 0",
                     bif.sda_oen, bif.busy);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (dut.state !== ST_IDLE || bif.reg_addr !== 8'h00) begin
            errors++;
            $display("FAIL mid_idle: got st=%0d ptr=%h want %0d 00",
                     dut.state, bif.reg_addr, ST_IDLE);
        end
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        #(4*Q);
        @(negedge clk);
        checks++;
        if (dut.state !== ST_IDLE || bif.sda_oen !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: got st=%0d oen=%b want %0d 1",
                     dut.state, bif.sda_oen, ST_IDLE);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            regfile[i] = 16'h0000;
        test_reset();
        test_write();
        test_read();
        test_addr_mismatch();
        test_wrap();
        test_partial();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
